// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, control tokens and alignment FSM state codes.
package tmds_pkg;

  localparam int TMDS_W        = 10;
  localparam int TMDS_NUM_CTRL = 4;

  localparam logic [TMDS_W-1:0] TMDS_CTRL0 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL1 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTRL2 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL3 = 10'b1010101011;

  localparam logic [TMDS_W-1:0] TMDS_CTRL_TOKENS [TMDS_NUM_CTRL] =
    '{TMDS_CTRL0, TMDS_CTRL1, TMDS_CTRL2, TMDS_CTRL3};

  typedef logic [2:0] tmds_state_t;

  localparam tmds_state_t ST_IDLE   = 3'd0;
  localparam tmds_state_t ST_SEARCH = 3'd1;
  localparam tmds_state_t ST_SLIP   = 3'd2;
  localparam tmds_state_t ST_WAIT   = 3'd3;
  localparam tmds_state_t ST_LOCKED = 3'd4;

endpackage

// File: rtl/tmds_token_det.sv
// Combinational matcher: flags a 10-bit word equal to any of the four TMDS control tokens.
module tmds_token_det
  import tmds_pkg::*;
(
  input  logic [TMDS_W-1:0] i_word,
  output logic              o_is_token
);

  logic [TMDS_NUM_CTRL-1:0] hit;

  generate
    for (genvar gi = 0; gi < TMDS_NUM_CTRL; gi++) begin : g_match
      assign hit[gi] = (i_word == TMDS_CTRL_TOKENS[gi]);
    end
  endgenerate

  assign o_is_token = |hit;

endmodule

// File: rtl/tmds_align_ctrl.sv
// Per-channel TMDS word-alignment controller: slips the de-serializer until control-token
// runs appear, then holds lock. Define TMDS_ALIGN_STATS_EN to add the o_relock_cnt output.
module tmds_align_ctrl
  import tmds_pkg::*;
#(
  parameter int TOKEN_RUN  = 8,
  parameter int SEARCH_WIN = 2048,
  parameter int SLIP_WAIT  = 4,
  parameter int MAX_SLIPS  = 10,
  parameter int LOSS_WIN   = 4096
) (
  input  logic              i_pixclk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [TMDS_W-1:0] i_encoded,
  output logic              o_bitslip,
  output logic              o_aligned,
  output logic [3:0]        o_slip_pos,
  output logic              o_fail
`ifdef TMDS_ALIGN_STATS_EN
  ,
  output logic [7:0]        o_relock_cnt
`endif
);

  localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
  localparam int WIN_W  = $clog2(SEARCH_WIN);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);
  localparam int LOSS_W = $clog2(LOSS_WIN);

  tmds_state_t       state_reg, state_next;
  logic [RUN_W-1:0]  run_cnt_reg, run_cnt_next;
  logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [LOSS_W-1:0] loss_cnt_reg, loss_cnt_next;
  logic [3:0]        slip_pos_reg, slip_pos_next;
  logic              fail_reg, fail_next;
  logic              bitslip_reg, bitslip_next;
  logic              aligned_reg, aligned_next;

  logic              is_token;
  logic [RUN_W-1:0]  run_inc;
  logic [RUN_W-1:0]  run_tok;
  logic              run_full;
  logic [LOSS_W-1:0] loss_inc;

  tmds_token_det u_token_det (
    .i_word     (i_encoded),
    .o_is_token (is_token)
  );

  always_comb begin
    run_inc  = (run_cnt_reg == RUN_W'(TOKEN_RUN)) ? run_cnt_reg : run_cnt_reg + RUN_W'(1);
    run_tok  = is_token ? run_inc : '0;
    run_full = is_token && (run_inc == RUN_W'(TOKEN_RUN));
    loss_inc = loss_cnt_reg + LOSS_W'(1);
  end

  always_comb begin
    state_next    = state_reg;
    run_cnt_next  = '0;
    win_cnt_next  = '0;
    wait_cnt_next = '0;
    loss_cnt_next = '0;
    slip_pos_next = slip_pos_reg;
    fail_next     = fail_reg;
    bitslip_next  = 1'b0;
    aligned_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        state_next = ST_SEARCH;
      end

      ST_SEARCH: begin
        run_cnt_next = run_tok;
        win_cnt_next = win_cnt_reg + WIN_W'(1);
        // A run completing on the last window word still locks rather than slipping.
        if (run_full) begin
          state_next   = ST_LOCKED;
          aligned_next = 1'b1;
          win_cnt_next = '0;
        end else if (win_cnt_reg == WIN_W'(SEARCH_WIN - 1)) begin
          state_next   = ST_SLIP;
          bitslip_next = 1'b1;
          win_cnt_next = '0;
          if (slip_pos_reg == 4'(MAX_SLIPS - 1)) begin
            slip_pos_next = '0;
            fail_next     = 1'b1;
          end else begin
            slip_pos_next = slip_pos_reg + 4'd1;
          end
        end
      end

      ST_SLIP: begin
        state_next = ST_WAIT;
      end

      ST_WAIT: begin
        wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        if (wait_cnt_reg == WAIT_W'(SLIP_WAIT - 1)) begin
          state_next    = ST_SEARCH;
          wait_cnt_next = '0;
        end
      end

      ST_LOCKED: begin
        run_cnt_next = run_tok;
        aligned_next = 1'b1;
        if (run_full) begin
          loss_cnt_next = '0;
        end else if (loss_inc == LOSS_W'(LOSS_WIN - 1)) begin
          state_next   = ST_SEARCH;
          aligned_next = 1'b0;
        end else begin
          loss_cnt_next = loss_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Disable overrides everything except the slip position and fail flag, which track the
    // de-serializer and survive an enable toggle.
    if (!i_en) begin
      state_next    = ST_IDLE;
      run_cnt_next  = '0;
      win_cnt_next  = '0;
      wait_cnt_next = '0;
      loss_cnt_next = '0;
      slip_pos_next = slip_pos_reg;
      fail_next     = fail_reg;
      bitslip_next  = 1'b0;
      aligned_next  = 1'b0;
    end
  end

  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      run_cnt_reg  <= '0;
      win_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      loss_cnt_reg <= '0;
      slip_pos_reg <= '0;
      fail_reg     <= 1'b0;
      bitslip_reg  <= 1'b0;
      aligned_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      run_cnt_reg  <= run_cnt_next;
      win_cnt_reg  <= win_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      loss_cnt_reg <= loss_cnt_next;
      slip_pos_reg <= slip_pos_next;
      fail_reg     <= fail_next;
      bitslip_reg  <= bitslip_next;
      aligned_reg  <= aligned_next;
    end
  end

  assign o_bitslip  = bitslip_reg;
  assign o_aligned  = aligned_reg;
  assign o_slip_pos = slip_pos_reg;
  assign o_fail     = fail_reg;

`ifdef TMDS_ALIGN_STATS_EN
  logic       relock_evt;
  logic [7:0] relock_cnt_reg;

  assign relock_evt = (state_reg == ST_LOCKED) && (state_next == ST_SEARCH);

  always_ff @(posedge i_pixclk or posedge i_rst) begin
    if (i_rst) begin
      relock_cnt_reg <= '0;
    end else if (relock_evt && (relock_cnt_reg != 8'hFF)) begin
      relock_cnt_reg <= relock_cnt_reg + 8'd1;
    end
  end

  assign o_relock_cnt = relock_cnt_reg;
`endif

endmodule

// File: tb/tb_tmds_align_ctrl.sv
// Directed bench for tmds_align_ctrl: lock, slip rotation, lock loss, fail wrap, enable and reset.
module tb_tmds_align_ctrl;

  localparam int SEARCH_WIN  = 2048;
  localparam int SLIP_WAIT   = 4;
  localparam int LOSS_WIN    = 4096;
  localparam int SLIP_PERIOD = SEARCH_WIN + SLIP_WAIT + 1;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

  logic       i_pixclk = 1'b0;
  logic       i_rst;
  logic       i_en;
  logic [9:0] i_encoded;
  logic       o_bitslip;
  logic       o_aligned;
  logic [3:0] o_slip_pos;
  logic       o_fail;
`ifdef TMDS_ALIGN_STATS_EN
  logic [7:0] o_relock_cnt;
`endif

  tmds_align_ctrl dut (
    .i_pixclk   (i_pixclk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_encoded  (i_encoded),
    .o_bitslip  (o_bitslip),
    .o_aligned  (o_aligned),
    .o_slip_pos (o_slip_pos),
    .o_fail     (o_fail)
`ifdef TMDS_ALIGN_STATS_EN
    ,
    .o_relock_cnt (o_relock_cnt)
`endif
  );

  always #5 i_pixclk = ~i_pixclk;

  int   vec_cnt   = 0;
  int   err_cnt   = 0;
  int   cyc       = 0;
  int   bs_count  = 0;
  int   double_bs = 0;
  logic prev_bs   = 1'b0;
  int   p_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  function automatic logic [9:0] rand_word();
    logic [9:0] w;
    do begin
      w = 10'($urandom);
    end while (w == TOK0 || w == TOK1 || w == TOK2 || w == TOK3);
    return w;
  endfunction

  // Present one word, let the DUT sample it, then observe just after the edge.
  task automatic tick(input logic [9:0] w);
    i_encoded = w;
    @(posedge i_pixclk);
    #1;
    cyc++;
    if (o_bitslip === 1'b1) begin
      bs_count++;
      if (prev_bs) double_bs++;
    end
    prev_bs = (o_bitslip === 1'b1);
  endtask

  task automatic ticks_rand(input int n);
    for (int i = 0; i < n; i++) tick(rand_word());
  endtask

  initial begin
    int base;
    int drop_cyc;
    int got;

    i_rst     = 1'b1;
    i_en      = 1'b0;
    i_encoded = '0;
    repeat (3) @(posedge i_pixclk);
    #1;
    check_val("rst_bitslip", o_bitslip, 0);
    check_val("rst_aligned", o_aligned, 0);
    check_val("rst_slip_pos", o_slip_pos, 0);
    check_val("rst_fail", o_fail, 0);
`ifdef TMDS_ALIGN_STATS_EN
    check_val("rst_relock", o_relock_cnt, 0);
`endif

    // Clean lock: tokens after random data, no slip needed.
    i_rst = 1'b0;
    i_en  = 1'b1;
    ticks_rand(100);
    for (int k = 1; k <= 20; k++) begin
      tick(TOK0);
      if (k == 7) check_val("lock_not_at_7th", o_aligned, 0);
      if (k == 8) check_val("lock_on_8th", o_aligned, 1);
    end
    check_val("lock_held_20", o_aligned, 1);
    check_val("lock_no_bitslip", bs_count, 0);
    check_val("lock_slip_pos", o_slip_pos, 0);

    // Loss window restarted by a token run, then a full loss window drops lock.
    ticks_rand(3000);
    repeat (8) tick(TOK1);
    ticks_rand(3000);
    check_val("loss_rerun_hold", o_aligned, 1);
    ticks_rand(LOSS_WIN - 2 - 3000);
    check_val("loss_at_4094", o_aligned, 1);
    tick(rand_word());
    check_val("loss_drop_4095", o_aligned, 0);
    check_val("loss_no_slip", bs_count, 0);
`ifdef TMDS_ALIGN_STATS_EN
    check_val("relock_1", o_relock_cnt, 1);
`endif

    // Broken run does not lock; a run ending on window expiry does.
    repeat (7) tick(TOK2);
    tick(rand_word());
    repeat (7) tick(TOK3);
    check_val("broken_run_no_lock", o_aligned, 0);
    ticks_rand(2040 - 15);
    for (int k = 1; k <= 8; k++) begin
      tick(TOK0);
      if (k == 7) check_val("edge_run_7", o_aligned, 0);
    end
    check_val("edge_run_lock", o_aligned, 1);
    check_val("edge_run_no_slip", bs_count, 0);
    check_val("edge_run_bitslip_low", o_bitslip, 0);

    ticks_rand(LOSS_WIN - 2);
    check_val("loss2_at_4094", o_aligned, 1);
    tick(rand_word());
    check_val("loss2_drop", o_aligned, 0);
    drop_cyc = cyc;
`ifdef TMDS_ALIGN_STATS_EN
    check_val("relock_2", o_relock_cnt, 2);
`endif

    // Stream is aligned only after three slips seen by the bench.
    base = bs_count;
    got  = 0;
    p_cyc.delete();
    for (int n = 0; n < 4 * SLIP_PERIOD + 200 && got == 0; n++) begin
      if ((bs_count - base) == 3 && (cyc % 64) < 12) tick(TOK0);
      else tick(rand_word());
      if (o_bitslip === 1'b1) p_cyc.push_back(cyc);
      if (o_aligned === 1'b1) got = 1;
    end
    check_val("rot_locked", got, 1);
    check_val("rot_pulses", bs_count - base, 3);
    check_val("rot_slip_pos", o_slip_pos, 3);
    if (p_cyc.size() >= 3) begin
      check_val("rot_first_slip", p_cyc[0] - drop_cyc, SEARCH_WIN);
      check_val("rot_gap1", p_cyc[1] - p_cyc[0], SLIP_PERIOD);
      check_val("rot_gap2", p_cyc[2] - p_cyc[1], SLIP_PERIOD);
    end

    // Lose lock, slip to position 5, then disable mid-search.
    got = 0;
    for (int n = 0; n < LOSS_WIN + 10 && got == 0; n++) begin
      tick(rand_word());
      if (o_aligned === 1'b0) got = 1;
    end
    check_val("en_pre_drop", got, 1);
    got = 0;
    for (int n = 0; n < 3 * SLIP_PERIOD && got == 0; n++) begin
      tick(rand_word());
      if (o_bitslip === 1'b1 && o_slip_pos == 4'd5) got = 1;
    end
    check_val("en_reach_pos5", got, 1);
    ticks_rand(SLIP_WAIT + 10);
    i_en = 1'b0;
    base = bs_count;
    repeat (20) tick(TOK0);
    ticks_rand(SEARCH_WIN + 100);
    check_val("en_off_no_slip", bs_count - base, 0);
    check_val("en_off_aligned", o_aligned, 0);
    check_val("en_off_pos_kept", o_slip_pos, 5);
    check_val("en_off_fail", o_fail, 0);
`ifdef TMDS_ALIGN_STATS_EN
    check_val("relock_3", o_relock_cnt, 3);
`endif

    // Resume, slip once more, then reset asynchronously during WAIT.
    i_en = 1'b1;
    got  = 0;
    for (int n = 0; n < SLIP_PERIOD + 20 && got == 0; n++) begin
      tick(rand_word());
      if (o_bitslip === 1'b1) got = 1;
    end
    check_val("resume_pos6", o_slip_pos, 6);
    tick(rand_word());
    #2;
    i_rst = 1'b1;
    #1;
    check_val("async_rst_pos", o_slip_pos, 0);
    check_val("async_rst_bitslip", o_bitslip, 0);
    check_val("async_rst_aligned", o_aligned, 0);
`ifdef TMDS_ALIGN_STATS_EN
    check_val("async_rst_relock", o_relock_cnt, 0);
`endif
    @(posedge i_pixclk);
    #1;
    i_rst   = 1'b0;
    prev_bs = 1'b0;

    // Random data only: full rotation sets the sticky fail flag, search continues.
    base = bs_count;
    got  = 0;
    for (int n = 0; n < 10 * (SEARCH_WIN + 5) + 100 && got == 0; n++) begin
      tick(rand_word());
      if (o_fail === 1'b1) got = 1;
    end
    check_val("fail_set", got, 1);
    check_val("fail_pulses", bs_count - base, 10);
    check_val("fail_wrap_pos", o_slip_pos, 0);
    check_val("fail_with_slip", o_bitslip, 1);
    ticks_rand(SLIP_PERIOD);
    check_val("fail_sticky", o_fail, 1);
    check_val("fail_search_continues", o_slip_pos, 1);
    check_val("fail_aligned", o_aligned, 0);
    check_val("bitslip_single_cycle", double_bs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
